// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// FSM states, opcode/funct values, ALU codes and datapath select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_IEXEC,
        S_IWB,
        S_JUMP,
        S_JALWB
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_DATA   = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // States after which the instruction is complete and counts as retired.
    function automatic logic is_final(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) ||
               (s == S_BRANCH) || (s == S_IWB) || (s == S_JUMP) || (s == S_JALWB);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: turns the FSM's 2-bit ALUOp plus Funct into ALUControl,
// and flags whether Funct names a supported R-type operation.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    logic [2:0] funct_ctrl;

    always_comb begin
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  funct_ctrl = ALU_ADD;
            FN_SUB:  funct_ctrl = ALU_SUB;
            FN_AND:  funct_ctrl = ALU_AND;
            FN_OR:   funct_ctrl = ALU_OR;
            FN_SLT:  funct_ctrl = ALU_SLT;
            default: begin
                funct_ctrl  = ALU_ADD;
                funct_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_OR:    alu_control = ALU_OR;
            default:     alu_control = funct_ctrl;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit with memory wait states, sticky illegal flag
// and retired-instruction counter. Define MIPS_JUMP_EN to add j/jal.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 0,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ExtZero,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUControl,
    output logic             Illegal,
    output logic [CNT_W-1:0] Retired
);

    localparam logic [1:0] LAT = 2'(MEM_LAT);

    state_t     state;
    state_t     nxt;
    logic [1:0] wcnt;
    logic       wait_done;
    logic       dec_illegal;
    logic       pc_write;
    logic       branch;
    logic       alu_en;
    logic [1:0] alu_op;
    logic [2:0] dec_ctrl;
    logic       funct_valid;

    assign wait_done = (wcnt == LAT);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (dec_ctrl),
        .funct_valid (funct_valid)
    );

    always_comb begin
        nxt         = state;
        dec_illegal = 1'b0;
        case (state)
            S_FETCH:    if (wait_done) nxt = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:      nxt = S_MEMADR;
                    OP_BEQ:            nxt = S_BRANCH;
                    OP_ADDI, OP_ORI:   nxt = S_IEXEC;
                    OP_RTYPE: begin
                        nxt         = funct_valid ? S_EXECUTE : S_FETCH;
                        dec_illegal = !funct_valid;
                    end
`ifdef MIPS_JUMP_EN
                    OP_J, OP_JAL:      nxt = S_JUMP;
`endif
                    default: begin
                        nxt         = S_FETCH;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   nxt = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (wait_done) nxt = S_MEMWB;
            S_MEMWRITE: if (wait_done) nxt = S_FETCH;
            S_EXECUTE:  nxt = S_ALUWB;
            S_IEXEC:    nxt = S_IWB;
            S_JUMP:     nxt = (Opcode == OP_JAL) ? S_JALWB : S_FETCH;
            default:    nxt = S_FETCH;
        endcase
    end

    // Wait states stay put until wcnt reaches the latency; every other state
    // advances each cycle, so a state change is what clears wcnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            wcnt    <= '0;
            Illegal <= 1'b0;
            Retired <= '0;
        end else begin
            state <= nxt;
            wcnt  <= (nxt != state) ? 2'd0 : wcnt + 2'd1;
            if (dec_illegal)
                Illegal <= 1'b1;
            if (nxt == S_FETCH && is_final(state))
                Retired <= Retired + CNT_W'(1);
        end
    end

    always_comb begin
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = REGDST_RT;
        MemtoReg = M2R_ALUOUT;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_B;
        ExtZero  = 1'b0;
        PCSrc    = PCSRC_ALU;
        pc_write = 1'b0;
        branch   = 1'b0;
        alu_en   = 1'b0;
        alu_op   = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB  = SRCB_FOUR;
                alu_en   = 1'b1;
                IRWrite  = wait_done;
                pc_write = wait_done;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH2;
                alu_en  = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                alu_en  = 1'b1;
            end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = M2R_DATA;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_en  = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = REGDST_RD;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_en  = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                alu_en  = 1'b1;
                ExtZero = (Opcode == OP_ORI);
                alu_op  = (Opcode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                ExtZero  = (Opcode == OP_ORI);
            end
`ifdef MIPS_JUMP_EN
            S_JUMP: begin
                PCSrc    = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            S_JALWB: begin
                RegDst   = REGDST_RA;
                MemtoReg = M2R_PC;
                RegWrite = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign ALUControl = alu_en ? dec_ctrl : 3'b000;
    assign PCEn       = pc_write | (branch & Zero);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: three instances (MEM_LAT 0,1,2, 4-bit counter)
// checked cycle by cycle against a per-instruction expected-output table.
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extzero;
        logic [1:0] pcsrc;
        logic [2:0] aluctrl;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [3];
    logic [5:0] opc [3];
    logic [5:0] fnc [3];
    logic       zer [3];
    logic       pcen [3], iord [3], memwrite [3], irwrite [3];
    logic       regwrite [3], alusrca [3], extzero [3], illegal [3];
    logic [1:0] regdst [3], memtoreg [3], alusrcb [3], pcsrc [3];
    logic [2:0] aluctrl [3];
    logic [3:0] retired [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips_mc_ctrl #(.MEM_LAT(g), .CNT_W(4)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .Opcode     (opc[g]),
            .Funct      (fnc[g]),
            .Zero       (zer[g]),
            .PCEn       (pcen[g]),
            .IorD       (iord[g]),
            .MemWrite   (memwrite[g]),
            .IRWrite    (irwrite[g]),
            .RegDst     (regdst[g]),
            .MemtoReg   (memtoreg[g]),
            .RegWrite   (regwrite[g]),
            .ALUSrcA    (alusrca[g]),
            .ALUSrcB    (alusrcb[g]),
            .ExtZero    (extzero[g]),
            .PCSrc      (pcsrc[g]),
            .ALUControl (aluctrl[g]),
            .Illegal    (illegal[g]),
            .Retired    (retired[g])
        );
    end

    int   checks = 0;
    int   errors = 0;
    out_t exp_q [$];
    logic       m_ill [3];
    logic [3:0] m_ret [3];

    function automatic out_t act(input int l);
        out_t o;
        o.pcen     = pcen[l];
        o.iord     = iord[l];
        o.memwrite = memwrite[l];
        o.irwrite  = irwrite[l];
        o.regdst   = regdst[l];
        o.memtoreg = memtoreg[l];
        o.regwrite = regwrite[l];
        o.alusrca  = alusrca[l];
        o.alusrcb  = alusrcb[l];
        o.extzero  = extzero[l];
        o.pcsrc    = pcsrc[l];
        o.aluctrl  = aluctrl[l];
        return o;
    endfunction

    function automatic out_t fetch_exp(input int lat, input int i);
        out_t o = '0;
        o.alusrcb = 2'b01;
        o.aluctrl = 3'b010;
        o.irwrite = (i == lat);
        o.pcen    = (i == lat);
        return o;
    endfunction

    function automatic bit alu_of(input logic [5:0] fn, output logic [2:0] c);
        c = 3'b000;
        case (fn)
            6'h20: c = 3'b010;
            6'h22: c = 3'b110;
            6'h24: c = 3'b000;
            6'h25: c = 3'b001;
            6'h2A: c = 3'b111;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // Fills exp_q with one expected output word per cycle of the instruction;
    // returns 1 if the instruction is legal (retires), 0 if illegal.
    function automatic bit build(input int lat, input logic [5:0] op, input logic [5:0] fn, input logic z);
        out_t       o;
        logic [2:0] c;
        bit         legal = 1'b1;
        exp_q.delete();
        for (int i = 0; i <= lat; i++) exp_q.push_back(fetch_exp(lat, i));
        o = '0; o.alusrcb = 2'b11; o.aluctrl = 3'b010; exp_q.push_back(o);
        if (op == 6'h00 && alu_of(fn, c)) begin
            o = '0; o.alusrca = 1'b1; o.aluctrl = c; exp_q.push_back(o);
            o = '0; o.regdst = 2'b01; o.regwrite = 1'b1; exp_q.push_back(o);
        end else if (op == 6'h23 || op == 6'h2B) begin
            o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluctrl = 3'b010; exp_q.push_back(o);
            for (int i = 0; i <= lat; i++) begin
                o = '0; o.iord = 1'b1; o.memwrite = (op == 6'h2B); exp_q.push_back(o);
            end
            if (op == 6'h23) begin
                o = '0; o.memtoreg = 2'b01; o.regwrite = 1'b1; exp_q.push_back(o);
            end
        end else if (op == 6'h04) begin
            o = '0; o.alusrca = 1'b1; o.aluctrl = 3'b110; o.pcsrc = 2'b01; o.pcen = z; exp_q.push_back(o);
        end else if (op == 6'h08 || op == 6'h0D) begin
            o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
            o.extzero = (op == 6'h0D);
            o.aluctrl = (op == 6'h0D) ? 3'b001 : 3'b010;
            exp_q.push_back(o);
            o = '0; o.regwrite = 1'b1; o.extzero = (op == 6'h0D); exp_q.push_back(o);
        end
`ifdef MIPS_JUMP_EN
        else if (op == 6'h02 || op == 6'h03) begin
            o = '0; o.pcsrc = 2'b10; o.pcen = 1'b1; exp_q.push_back(o);
            if (op == 6'h03) begin
                o = '0; o.regdst = 2'b10; o.memtoreg = 2'b10; o.regwrite = 1'b1; exp_q.push_back(o);
            end
        end
`endif
        else legal = 1'b0;
        return legal;
    endfunction

    // Runs one instruction on lane l; abort_at >= 0 asserts rst after that cycle.
    task automatic run_instr(input string name, input int l, input logic [5:0] op,
                             input logic [5:0] fn, input logic z, input int abort_at);
        bit   legal;
        out_t a;
        legal = build(l, op, fn, z);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin
                rst[l] = 1'b0; opc[l] = op; fnc[l] = fn; zer[l] = z;
            end
            #1;
            a = act(l);
            checks++;
            if (a !== exp_q[k]) begin
                errors++;
                $display("FAIL %s lane%0d op=%h cyc%0d outputs got %h want %h", name, l, op, k, a, exp_q[k]);
            end
            checks++;
            if ({illegal[l], retired[l]} !== {m_ill[l], m_ret[l]}) begin
                errors++;
                $display("FAIL %s lane%0d op=%h cyc%0d illegal/retired got %b/%0d want %b/%0d",
                         name, l, op, k, illegal[l], retired[l], m_ill[l], m_ret[l]);
            end
            if (k == abort_at) begin
                rst[l] = 1'b1;
                m_ill[l] = 1'b0;
                m_ret[l] = '0;
                return;
            end
        end
        if (legal) m_ret[l] = m_ret[l] + 4'd1;
        else       m_ill[l] = 1'b1;
    endtask

    // Checks the lane sits in FETCH cycle 0 with model flags, then parks it in reset.
    task automatic check_idle(input string name, input int l);
        out_t a;
        out_t e;
        @(negedge clk);
        #1;
        a = act(l);
        e = fetch_exp(l, 0);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s lane%0d idle outputs got %h want %h", name, l, a, e);
        end
        checks++;
        if ({illegal[l], retired[l]} !== {m_ill[l], m_ret[l]}) begin
            errors++;
            $display("FAIL %s lane%0d idle illegal/retired got %b/%0d want %b/%0d",
                     name, l, illegal[l], retired[l], m_ill[l], m_ret[l]);
        end
        rst[l] = 1'b1;
        m_ill[l] = 1'b0;
        m_ret[l] = '0;
    endtask

    task automatic do_reset(input int l);
        @(negedge clk);
        rst[l] = 1'b1;
        m_ill[l] = 1'b0;
        m_ret[l] = '0;
        check_idle("reset", l);
    endtask

    task automatic test_reset();
        for (int l = 0; l < 3; l++) do_reset(l);
    endtask

    task automatic test_add();
        do_reset(0);
        run_instr("add", 0, 6'h00, 6'h20, 1'b0, -1);
        checks++;
        if (retired[0] !== 4'd0) begin
            errors++;
            $display("FAIL add_retire_before_edge got %0d want 0", retired[0]);
        end
        check_idle("add_retired", 0);
    endtask

    task automatic test_beq();
        do_reset(0);
        run_instr("beq_taken", 0, 6'h04, 6'h00, 1'b1, -1);
        run_instr("beq_not_taken", 0, 6'h04, 6'h00, 1'b0, -1);
        check_idle("beq_end", 0);
    endtask

    task automatic test_lw_lat2();
        do_reset(2);
        run_instr("lw_lat2", 2, 6'h23, 6'h00, 1'b0, -1);
        run_instr("sw_lat2", 2, 6'h2B, 6'h00, 1'b0, -1);
        check_idle("lw_lat2_end", 2);
    endtask

    task automatic test_illegal();
        do_reset(1);
        run_instr("illegal_op", 1, 6'h3F, 6'h20, 1'b0, -1);
        run_instr("after_illegal", 1, 6'h00, 6'h25, 1'b0, -1);
        run_instr("illegal_funct", 1, 6'h00, 6'h3F, 1'b0, -1);
        run_instr("ori_sticky", 1, 6'h0D, 6'h00, 1'b0, -1);
        check_idle("illegal_end", 1);
    endtask

    task automatic test_reset_in_memwrite();
        do_reset(1);
        run_instr("addi_pre", 1, 6'h08, 6'h00, 1'b0, -1);
        run_instr("illegal_pre", 1, 6'h3F, 6'h00, 1'b0, -1);
        // sw with MEM_LAT=1: FETCH x2, DECODE, MEMADR, then MEMWRITE cycle 0 at index 4
        run_instr("sw_abort", 1, 6'h2B, 6'h00, 1'b0, 4);
        check_idle("after_abort", 1);
    endtask

    task automatic test_jump();
        for (int l = 0; l < 3; l += 2) begin
            do_reset(l);
            run_instr("jal", l, 6'h03, 6'h00, 1'b0, -1);
            run_instr("j", l, 6'h02, 6'h00, 1'b1, -1);
            check_idle("jump_end", l);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] op;
        logic [5:0] fn;
        for (int l = 0; l < 3; l++) begin
            do_reset(l);
            for (int n = 0; n < 40; n++) begin
                case ($urandom_range(0, 9))
                    0, 1: op = 6'h00;
                    2: op = 6'h23;
                    3: op = 6'h2B;
                    4: op = 6'h08;
                    5: op = 6'h0D;
                    6: op = 6'h04;
                    7: op = 6'h02;
                    8: op = 6'h03;
                    default: op = 6'($urandom);
                endcase
                case ($urandom_range(0, 5))
                    0: fn = 6'h20;
                    1: fn = 6'h22;
                    2: fn = 6'h24;
                    3: fn = 6'h25;
                    4: fn = 6'h2A;
                    default: fn = 6'($urandom);
                endcase
                run_instr("random", l, op, fn, 1'($urandom), -1);
            end
            check_idle("random_end", l);
        end
    endtask

    initial begin
        for (int l = 0; l < 3; l++) begin
            rst[l] = 1'b1; opc[l] = '0; fnc[l] = '0; zer[l] = 1'b0;
            m_ill[l] = 1'b0; m_ret[l] = '0;
        end
        test_reset();
        test_add();
        test_beq();
        test_lw_lat2();
        test_illegal();
        test_reset_in_memwrite();
        test_jump();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
